// File: rtl/cmos_split_pkg.sv
// Shared definitions for the dual-camera line merger/splitter pair:
// default geometry and the splitter FSM encoding.
package cmos_split_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int H_HALF_DEF = 640;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_LEFT  = 3'd2,
    ST_RIGHT = 3'd3,
    ST_DROP  = 3'd4
  } state_e;

  // True while a line is still expected to deliver more half-line pixels.
  function automatic logic in_line_half(input state_e st);
    return (st == ST_LEFT) || (st == ST_RIGHT);
  endfunction

endpackage

// File: rtl/cmos_split_if.sv
// Merged DVP input stream plus the split dual-stream output and error flags.
interface cmos_split_if
  import cmos_split_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              in_vsync;
  logic              in_href;
  logic              in_de;
  logic [DATA_W-1:0] in_data;
  logic              out_vsync;
  logic              out_href;
  logic              out_de;
  logic [DATA_W-1:0] out0_data;
  logic [DATA_W-1:0] out1_data;
  logic              err_short;
  logic              err_long;

  modport master (
    output in_vsync, in_href, in_de, in_data,
    input  out_vsync, out_href, out_de, out0_data, out1_data, err_short, err_long
  );

  modport slave (
    input  in_vsync, in_href, in_de, in_data,
    output out_vsync, out_href, out_de, out0_data, out1_data, err_short, err_long
  );

endinterface

// File: rtl/cmos_split_line_buf.sv
// Single-port synchronous line buffer: one write or one registered read per
// cycle; storage has no reset so it maps onto block RAM.
module line_buf_sp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              pclk,
  input  logic              sys_rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] rdata_r;

  // Storage write port.
  always_ff @(posedge pclk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Registered read port, cleared on reset so the output starts at zero.
  always_ff @(posedge pclk) begin
    if (sys_rst) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/cmos_split.sv
// Splits a merged double-width DVP line into two time-aligned half-line
// streams; the left half is parked in a line buffer until the right arrives.
module cmos_split
  import cmos_split_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int H_HALF = H_HALF_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic         pclk,
  input logic         sys_rst,
  cmos_split_if.slave bus
);

  localparam logic [ADDR_W:0] HALF_L   = (ADDR_W+1)'(H_HALF);
  localparam logic [ADDR_W:0] LAST_L_L = (ADDR_W+1)'(H_HALF - 1);
  localparam logic [ADDR_W:0] LAST_R_L = (ADDR_W+1)'(2 * H_HALF - 1);

  state_e            state_r;
  logic [ADDR_W:0]   col_r;
  logic              href_d_r;
  logic              out_vsync_r;
  logic              out_href_r;
  logic              out_de_r;
  logic [DATA_W-1:0] out1_data_r;
  logic              err_short_r;
  logic              err_long_r;

  logic              pix_s;
  logic              vs_rise_s;
  logic              left_acc_s;
  logic              right_acc_s;
  logic              short_s;
  logic              long_s;
  logic              line_end_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [DATA_W-1:0] rd_data_s;

  // Pixel acceptance, error events and buffer address for this cycle.
  always_comb begin
    pix_s       = bus.in_href & bus.in_de & ~bus.in_vsync;
    vs_rise_s   = bus.in_vsync & ~out_vsync_r;
    line_end_s  = bus.in_vsync | ~bus.in_href;
    left_acc_s  = 1'b0;
    right_acc_s = 1'b0;
    case (state_r)
      // A line only starts from a low href, so a vsync abort mid-line
      // does not restart splitting on the tail of that line.
      ST_IDLE:  left_acc_s  = pix_s & ~href_d_r;
      ST_LEFT:  left_acc_s  = pix_s;
      ST_RIGHT: right_acc_s = pix_s;
      default: begin
        left_acc_s  = 1'b0;
        right_acc_s = 1'b0;
      end
    endcase
    short_s = in_line_half(state_r) & ~bus.in_href;
    long_s  = (state_r == ST_DROP) & bus.in_href & bus.in_de;
    if (right_acc_s) begin
      ram_addr_s = ADDR_W'(col_r - HALF_L);
    end else begin
      ram_addr_s = col_r[ADDR_W-1:0];
    end
  end

  // Splitter FSM, column counter, output pipeline and sticky error flags.
  always_ff @(posedge pclk) begin
    if (sys_rst) begin
      state_r     <= ST_SYNC;
      col_r       <= '0;
      href_d_r    <= 1'b0;
      out_vsync_r <= 1'b0;
      out_href_r  <= 1'b0;
      out_de_r    <= 1'b0;
      out1_data_r <= '0;
      err_short_r <= 1'b0;
      err_long_r  <= 1'b0;
    end else begin
      href_d_r    <= bus.in_href;
      out_vsync_r <= bus.in_vsync;
      out_de_r    <= right_acc_s;
      if (right_acc_s) begin
        out1_data_r <= bus.in_data;
      end

      if (line_end_s) begin
        col_r <= '0;
      end else if (bus.in_de) begin
        col_r <= col_r + 1'b1;
      end

      if (line_end_s) begin
        out_href_r <= 1'b0;
      end else if (right_acc_s) begin
        out_href_r <= 1'b1;
      end else if (state_r == ST_DROP) begin
        out_href_r <= 1'b0;
      end

      // Setting beats the vsync-rising clear on the same edge.
      if (short_s) begin
        err_short_r <= 1'b1;
      end else if (vs_rise_s) begin
        err_short_r <= 1'b0;
      end
      if (long_s) begin
        err_long_r <= 1'b1;
      end else if (vs_rise_s) begin
        err_long_r <= 1'b0;
      end

      case (state_r)
        ST_SYNC: begin
          if (!bus.in_href) state_r <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!bus.in_vsync && bus.in_href && !href_d_r) begin
            state_r <= (left_acc_s && col_r == LAST_L_L) ? ST_RIGHT : ST_LEFT;
          end
        end
        ST_LEFT: begin
          if (line_end_s) state_r <= ST_IDLE;
          else if (left_acc_s && col_r == LAST_L_L) state_r <= ST_RIGHT;
        end
        ST_RIGHT: begin
          if (line_end_s) state_r <= ST_IDLE;
          else if (right_acc_s && col_r == LAST_R_L) state_r <= ST_DROP;
        end
        ST_DROP: begin
          if (line_end_s) state_r <= ST_IDLE;
        end
        default: state_r <= ST_SYNC;
      endcase
    end
  end

  line_buf_sp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_line_buf (
    .pclk    (pclk),
    .sys_rst (sys_rst),
    .we      (left_acc_s),
    .re      (right_acc_s),
    .addr    (ram_addr_s),
    .wdata   (bus.in_data),
    .rdata   (rd_data_s)
  );

  assign bus.out_vsync = out_vsync_r;
  assign bus.out_href  = out_href_r;
  assign bus.out_de    = out_de_r;
  assign bus.out0_data = rd_data_s;
  assign bus.out1_data = out1_data_r;
  assign bus.err_short = err_short_r;
  assign bus.err_long  = err_long_r;

endmodule

// File: tb/tb_cmos_split.sv
// Directed bench for cmos_split with H_HALF=4: merged lines of pixel values
// 1..N and hand-derived expected output pairs (k, k+4).
module tb_cmos_split;

  logic pclk;
  logic sys_rst;

  int checks_cnt;
  int fail_cnt;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int href_cyc;
  int gap_cyc;
  int href_rise;
  logic href_prev;

  cmos_split_if #(.DATA_W(16)) bus ();

  cmos_split #(
    .DATA_W (16),
    .H_HALF (4),
    .ADDR_W (2)
  ) dut (
    .pclk    (pclk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Collect every output pair and out_href activity away from the clock edge.
  always @(negedge pclk) begin
    if (bus.out_de) begin
      q0.push_back(bus.out0_data);
      q1.push_back(bus.out1_data);
    end
    if (bus.out_href) href_cyc++;
    if (bus.out_href && !bus.out_de) gap_cyc++;
    if (bus.out_href && !href_prev) href_rise++;
    href_prev = bus.out_href;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic h, input logic d, input logic [15:0] px);
    bus.in_vsync = v;
    bus.in_href  = h;
    bus.in_de    = d;
    bus.in_data  = px;
    @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic mon_clear();
    q0.delete();
    q1.delete();
    href_cyc  = 0;
    gap_cyc   = 0;
    href_rise = 0;
  endtask

  task automatic drive_line(input int n, input bit gap);
    for (int k = 1; k <= n; k++) begin
      step(1'b0, 1'b1, 1'b1, 16'(k));
      if (gap) step(1'b0, 1'b1, 1'b0, 16'd0);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic check_pairs(input string tag, input int n);
    check_eq({tag, "_npairs"}, q0.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < q0.size()) begin
        check_eq({tag, "_out0"}, q0[i], i + 1);
        check_eq({tag, "_out1"}, q1[i], i + 5);
      end
    end
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    href_prev  = 1'b0;
    mon_clear();
    sys_rst      = 1'b1;
    bus.in_vsync = 1'b0;
    bus.in_href  = 1'b0;
    bus.in_de    = 1'b0;
    bus.in_data  = 16'd0;
    @(negedge pclk);
    step(1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 1'b0, 16'd0);

    check_eq("rst_out_de", bus.out_de, 1'b0);
    check_eq("rst_out_href", bus.out_href, 1'b0);
    check_eq("rst_out_vsync", bus.out_vsync, 1'b0);
    check_eq("rst_out0", bus.out0_data, 16'd0);
    check_eq("rst_out1", bus.out1_data, 16'd0);
    check_eq("rst_err_short", bus.err_short, 1'b0);
    check_eq("rst_err_long", bus.err_long, 1'b0);

    // Continuous line 1..8, checked cycle by cycle.
    sys_rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 1'b0, 16'd0);
    for (int k = 1; k <= 4; k++) step(1'b0, 1'b1, 1'b1, 16'(k));
    check_eq("cont_no_de_left", bus.out_de, 1'b0);
    check_eq("cont_no_href_left", bus.out_href, 1'b0);
    for (int k = 5; k <= 8; k++) begin
      step(1'b0, 1'b1, 1'b1, 16'(k));
      check_eq("cont_de", bus.out_de, 1'b1);
      check_eq("cont_href", bus.out_href, 1'b1);
      check_eq("cont_out0", bus.out0_data, 16'(k - 4));
      check_eq("cont_out1", bus.out1_data, 16'(k));
    end
    step(1'b0, 1'b0, 1'b0, 16'd0);
    check_eq("cont_de_end", bus.out_de, 1'b0);
    check_eq("cont_href_end", bus.out_href, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'd0);
    check_eq("cont_err_short", bus.err_short, 1'b0);
    check_eq("cont_err_long", bus.err_long, 1'b0);

    // Line 1..8 with a de gap after every pixel.
    mon_clear();
    drive_line(8, 1'b1);
    check_pairs("gap", 4);
    check_eq("gap_href_cycles", href_cyc, 7);
    check_eq("gap_de_gaps", gap_cyc, 3);
    check_eq("gap_href_rises", href_rise, 1);
    check_eq("gap_err_short", bus.err_short, 1'b0);

    // Short line of 6 pixels.
    mon_clear();
    drive_line(6, 1'b0);
    check_pairs("short", 2);
    check_eq("short_href_cycles", href_cyc, 2);
    check_eq("short_err_short", bus.err_short, 1'b1);
    check_eq("short_err_long", bus.err_long, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'd0);
    check_eq("short_vs_clear", bus.err_short, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'd0);

    // Long line of 10 pixels.
    mon_clear();
    drive_line(10, 1'b0);
    check_pairs("long", 4);
    check_eq("long_href_cycles", href_cyc, 4);
    check_eq("long_err_long", bus.err_long, 1'b1);
    check_eq("long_err_short", bus.err_short, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'd0);
    check_eq("long_vs_clear", bus.err_long, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'd0);

    // Reset applied and released while href is high.
    step(1'b0, 1'b1, 1'b1, 16'd1);
    step(1'b0, 1'b1, 1'b1, 16'd2);
    sys_rst = 1'b1;
    step(1'b0, 1'b1, 1'b1, 16'd3);
    sys_rst = 1'b0;
    mon_clear();
    for (int k = 4; k <= 8; k++) step(1'b0, 1'b1, 1'b1, 16'(k));
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 1'b0, 16'd0);
    check_eq("rstmid_no_de", q0.size(), 0);
    check_eq("rstmid_err_short", bus.err_short, 1'b0);
    mon_clear();
    drive_line(8, 1'b0);
    check_pairs("rstmid_next", 4);

    // vsync pulse on pixel 3 aborts the line.
    mon_clear();
    step(1'b0, 1'b1, 1'b1, 16'd1);
    step(1'b0, 1'b1, 1'b1, 16'd2);
    check_eq("vs_ovs_pre", bus.out_vsync, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'd3);
    check_eq("vs_ovs_hi", bus.out_vsync, 1'b1);
    step(1'b0, 1'b1, 1'b1, 16'd4);
    check_eq("vs_ovs_lo", bus.out_vsync, 1'b0);
    for (int k = 5; k <= 8; k++) step(1'b0, 1'b1, 1'b1, 16'(k));
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 1'b0, 16'd0);
    check_eq("vs_no_de", q0.size(), 0);
    check_eq("vs_err_short", bus.err_short, 1'b0);
    mon_clear();
    drive_line(8, 1'b0);
    check_pairs("vs_next", 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
